// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared opcodes, funct7 selectors, ALU control codes and FSM state encoding
// for the multicycle controller.
package multicycle_ctrl_fsm_pkg;

    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_RR  = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1101;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_ctrl_decoder.sv
// ALU control decode from opcode/funct3/funct7; purely combinational, no
// handshake. Anything not explicitly decoded falls back to ADD.
module alu_ctrl_decoder
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter logic [6:0] P_SW  = OP_SW,
    parameter logic [6:0] P_LW  = OP_LW,
    parameter logic [6:0] P_IMM = OP_IMM,
    parameter logic [6:0] P_BEQ = OP_BEQ,
    parameter logic [6:0] P_RR  = OP_RR
) (
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        if (i_opcode == P_BEQ) begin
            o_alu_ctrl = ALU_SUB;
        end else if ((i_opcode == P_LW) || (i_opcode == P_SW)) begin
            o_alu_ctrl = ALU_ADD;
        end else if (i_opcode == P_RR) begin
            // Register-register ops need an exact funct7 match.
            case (i_funct3)
                3'b000: begin
                    if (i_funct7 == F7_ALT)       o_alu_ctrl = ALU_SUB;
                    else if (i_funct7 == F7_BASE) o_alu_ctrl = ALU_ADD;
                end
                3'b001: if (i_funct7 == F7_BASE) o_alu_ctrl = ALU_SLL;
                3'b010: if (i_funct7 == F7_BASE) o_alu_ctrl = ALU_SLT;
                3'b100: if (i_funct7 == F7_BASE) o_alu_ctrl = ALU_XOR;
                3'b101: begin
                    if (i_funct7 == F7_ALT)       o_alu_ctrl = ALU_SRA;
                    else if (i_funct7 == F7_BASE) o_alu_ctrl = ALU_SRL;
                end
                3'b110: if (i_funct7 == F7_BASE) o_alu_ctrl = ALU_OR;
                3'b111: if (i_funct7 == F7_BASE) o_alu_ctrl = ALU_AND;
                default: o_alu_ctrl = ALU_ADD;
            endcase
        end else if (i_opcode == P_IMM) begin
            // Upper immediate bits only matter for the right-shift pair.
            case (i_funct3)
                3'b000: o_alu_ctrl = ALU_ADD;
                3'b001: o_alu_ctrl = ALU_SLL;
                3'b010: o_alu_ctrl = ALU_SLT;
                3'b100: o_alu_ctrl = ALU_XOR;
                3'b101: begin
                    if (i_funct7 == F7_ALT)       o_alu_ctrl = ALU_SRA;
                    else if (i_funct7 == F7_BASE) o_alu_ctrl = ALU_SRL;
                end
                3'b110: o_alu_ctrl = ALU_OR;
                3'b111: o_alu_ctrl = ALU_AND;
                default: o_alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Five-state multicycle control unit (IF/ID/EX/MEM/WB), 5 cycles per instruction.
// No backpressure: walks the fixed sequence unconditionally; decode uses the latched IR.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter logic [6:0] SW        = OP_SW,
    parameter logic [6:0] LW        = OP_LW,
    parameter logic [6:0] IMMEDIATE = OP_IMM,
    parameter logic [6:0] BEQ       = OP_BEQ,
    parameter logic [6:0] RR        = OP_RR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    output logic        ALUSrc,
    output logic [3:0]  ALUCtrl,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        loadPC,
    output logic        PCSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  state
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_ir;
    logic        r_zero;

    logic [6:0]  w_opcode;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_imm;
    logic        w_is_rr;
    logic        w_is_beq;
    logic        w_unused_ir;

    assign w_opcode    = r_ir[6:0];
    assign w_is_lw     = (w_opcode == LW);
    assign w_is_sw     = (w_opcode == SW);
    assign w_is_imm    = (w_opcode == IMMEDIATE);
    assign w_is_rr     = (w_opcode == RR);
    assign w_is_beq    = (w_opcode == BEQ);
    assign w_unused_ir = ^{r_ir[24:15], r_ir[11:7]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IF;
            r_ir    <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IF) r_ir   <= instr;
            if (r_state == ST_EX) r_zero <= Zero;
        end
    end

    // Strobes depend only on registered state and IR, so they cannot glitch.
    always_comb begin
        w_next_state = ST_IF;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        loadPC       = 1'b0;
        PCSrc        = 1'b0;
        case (r_state)
            ST_IF:  w_next_state = ST_ID;
            ST_ID:  w_next_state = ST_EX;
            ST_EX:  w_next_state = ST_MEM;
            ST_MEM: begin
                w_next_state = ST_WB;
                MemWrite     = w_is_sw;
                MemRead      = w_is_lw;
            end
            ST_WB: begin
                w_next_state = ST_IF;
                RegWrite     = w_is_lw | w_is_rr | w_is_imm;
                MemRead      = w_is_lw;
                loadPC       = 1'b1;
                PCSrc        = w_is_beq & r_zero;
            end
            default: w_next_state = ST_IF;
        endcase
    end

    assign ALUSrc   = w_is_lw | w_is_sw | w_is_imm;
    assign MemToReg = w_is_lw;
    assign state    = r_state;

    alu_ctrl_decoder #(
        .P_SW  (SW),
        .P_LW  (LW),
        .P_IMM (IMMEDIATE),
        .P_BEQ (BEQ),
        .P_RR  (RR)
    ) u_alu_ctrl_decoder (
        .i_opcode   (r_ir[6:0]),
        .i_funct3   (r_ir[14:12]),
        .i_funct7   (r_ir[31:25]),
        .o_alu_ctrl (ALUCtrl)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle expected outputs are
// queued as each state's stimulus is driven and popped when sampled.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        RegWrite;
    logic        MemToReg;
    logic        loadPC;
    logic        PCSrc;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic       chk_alu;
        logic       alusrc;
        logic [3:0] aluctrl;
        logic       memtoreg;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       lpc;
        logic       pcs;
    } exp_t;

    exp_t  sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string cur_tag;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .Zero     (Zero),
        .ALUSrc   (ALUSrc),
        .ALUCtrl  (ALUCtrl),
        .RegWrite (RegWrite),
        .MemToReg (MemToReg),
        .loadPC   (loadPC),
        .PCSrc    (PCSrc),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .state    (state)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", cur_tag, tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        check_val($sformatf("state@%0d", e.st), 32'(state), 32'(e.st));
        check_val($sformatf("RegWrite@%0d", e.st), 32'(RegWrite), 32'(e.rw));
        check_val($sformatf("MemRead@%0d", e.st), 32'(MemRead), 32'(e.mr));
        check_val($sformatf("MemWrite@%0d", e.st), 32'(MemWrite), 32'(e.mw));
        check_val($sformatf("loadPC@%0d", e.st), 32'(loadPC), 32'(e.lpc));
        check_val($sformatf("PCSrc@%0d", e.st), 32'(PCSrc), 32'(e.pcs));
        if (e.chk_alu) begin
            check_val($sformatf("ALUSrc@%0d", e.st), 32'(ALUSrc), 32'(e.alusrc));
            check_val($sformatf("ALUCtrl@%0d", e.st), 32'(ALUCtrl), 32'(e.aluctrl));
            check_val($sformatf("MemToReg@%0d", e.st), 32'(MemToReg), 32'(e.memtoreg));
        end
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e = '{st: 3'd0, chk_alu: 1'b1, alusrc: 1'b0, aluctrl: 4'b0010, memtoreg: 1'b0,
              rw: 1'b0, mr: 1'b0, mw: 1'b0, lpc: 1'b0, pcs: 1'b0};
        sb_q.push_back(e);
    endtask

    // Called at a negedge with the DUT in IF. abort_at < 5 asserts reset in that state.
    task automatic run_instr(input string name, input logic [31:0] ins,
                             input logic z_ex, input logic z_mem, input logic chg,
                             input logic e_src, input logic [3:0] e_ctl, input logic e_m2r,
                             input logic e_rw, input logic e_mr, input logic e_mw,
                             input logic e_pcs, input int abort_at);
        exp_t e;
        cur_tag = name;
        for (int st = 0; st < 5; st++) begin
            if (st == 0)                instr = ins;
            else if (chg && st >= 2)    instr = $urandom();
            Zero = (st == 2) ? z_ex : ((st == 3) ? z_mem : 1'b0);
            e = '{st: 3'(st), chk_alu: (st >= 2), alusrc: e_src, aluctrl: e_ctl,
                  memtoreg: e_m2r, rw: (st == 4) && e_rw, mr: (st >= 3) && e_mr,
                  mw: (st == 3) && e_mw, lpc: (st == 4), pcs: (st == 4) && e_pcs};
            sb_q.push_back(e);
            compare_out();
            if (st == abort_at) begin
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (abort_at < 5) begin
            @(negedge clk);
            cur_tag = {name, ".after_rst"};
            push_reset_exp();
            compare_out();
            rst = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        instr = 32'hFFFF_FFFF;
        Zero  = 1'b1;
        repeat (2) @(negedge clk);
        cur_tag = "reset";
        push_reset_exp();
        compare_out();
        rst  = 1'b1;
        Zero = 1'b0;

        //        name         instr          zex   zmem  chg   src   ctl      m2r   rw    mr    mw    pcs  abort
        run_instr("add",       32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("sw",        32'h0020A223, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9);
        run_instr("beq_taken", 32'h00208463, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        run_instr("beq_zmem",  32'h00208463, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        run_instr("srai_chg",  32'h4030D093, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("sw_abort",  32'h0020A223, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        run_instr("add_post",  32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("op7f",      32'h0000007F, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        run_instr("lw",        32'h0000A083, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9);
        run_instr("sub",       32'h402081B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("xor",       32'h0020C1B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("slt",       32'h0020A1B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("or",        32'h0020E1B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("and",       32'h0020F1B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("srl",       32'h0020D1B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("rr_undef",  32'h022081B3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("ori",       32'h0FF0E093, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("slli",      32'h00109093, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("slti",      32'h0050A093, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr("beq_nt",    32'h00208463, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 SHALL have parameter SW, 7'b0100011, store opcode.
REQ-002 SHALL have parameter LW, 7'b0000011, load opcode.
REQ-003 SHALL have parameter IMMEDIATE, 7'b0010011, register-immediate ALU opcode.
REQ-004 SHALL have parameter BEQ, 7'b1100011, branch-equal opcode.
REQ-005 SHALL have parameter RR, 7'b0110011, register-register ALU opcode.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port instr  input  32  instruction word from instruction memory.
REQ-009 SHALL have port Zero  input  1  ALU zero flag from datapath.
REQ-010 SHALL have port ALUSrc  output  1  1 = immediate operand, 0 = register operand.
REQ-011 SHALL have port ALUCtrl  output  4  ALU operation code.
REQ-012 SHALL have port RegWrite  output  1  register-file write enable.
REQ-013 SHALL have port MemToReg  output  1  1 = write-back from data memory.
REQ-014 SHALL have port loadPC  output  1  PC update enable.
REQ-015 SHALL have port PCSrc  output  1  1 = branch target, 0 = PC+4.
REQ-016 SHALL have ports MemRead and MemWrite, each output, 1 bit: data-memory read and write strobes.
REQ-017 SHALL have port state  output  3  current FSM state, for debug.

Function
REQ-018 SHALL implement states IF=3'd0, ID=3'd1, EX=3'd2, MEM=3'd3, WB=3'd4, with the fixed sequence IF->ID->EX->MEM->WB->IF; one instruction takes 5 cycles; codes 5-7 SHALL go to IF.
REQ-019 SHALL latch instr into an internal instruction register (IR) on the IF->ID edge only; all decode uses IR, never live instr.
REQ-020 SHALL latch Zero into a flag register on the EX->MEM edge only.
REQ-021 ALUSrc, ALUCtrl and MemToReg SHALL be combinational from IR and valid in EX, MEM and WB: ALUSrc=1 for LW/SW/IMMEDIATE and 0 otherwise; MemToReg=1 for LW only.
REQ-022 ALUCtrl encoding: ADD/ADDI/LW/SW 0010, SUB/BEQ 0110, SLT/SLTI 0111, XOR/XORI 1101, OR/ORI 0001, AND/ANDI 0000, SLL/SLLI 1001, SRL/SRLI 1000, SRA/SRAI 1010; an undefined funct3/funct7 combination gives 0010.
REQ-023 For RR, funct7=0100000 selects SUB (funct3 000) or SRA (funct3 101); for IMMEDIATE, funct7 is used only when funct3=101.
REQ-024 MemWrite SHALL be 1 only in MEM for SW.
REQ-025 MemRead SHALL be 1 in MEM and WB for LW only.
REQ-026 RegWrite SHALL be 1 only in WB for LW/RR/IMMEDIATE, so there is exactly one write per instruction.
REQ-027 loadPC SHALL be 1 only in WB, for every opcode including unknown ones.
REQ-028 PCSrc SHALL be 1 only in WB for BEQ with the latched Zero flag at 1, and 0 otherwise.
REQ-029 An unknown opcode SHALL be treated as a NOP: full 5-state walk, no RegWrite/MemRead/MemWrite, PC+4.
REQ-030 Every strobe not listed as asserted SHALL be 0 in that state; no strobe SHALL glitch across states for a stable IR.

Reset
REQ-031 When rst=0 at posedge, the block SHALL set state=IF, IR=32'b0 and Zero flag=0; the outputs then read RegWrite, MemRead, MemWrite, loadPC, PCSrc, ALUSrc, MemToReg = 0 and ALUCtrl = 4'b0010 (IR=0 decodes as unknown opcode).
REQ-032 Reset asserted in any state SHALL abort the instruction: no write strobe in the cycle after the reset edge.
REQ-033 The first IF SHALL occur in the cycle after rst returns to 1.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the ALUCtrl codes and the state encoding.
REQ-035 A single combinational sub-module, alu_ctrl_decoder (opcode, funct3, funct7 -> ALUCtrl), SHALL be instantiated; everything else stays in the top module.

Verification
REQ-036 Directed test, ADD: instr=32'h002081B3 at IF -> ALUCtrl=0010 and ALUSrc=0 from EX; RegWrite=1 and loadPC=1 only in cycle 5 (WB).
REQ-037 Directed test, SW: instr=32'h0020A223 -> MemWrite=1 only in cycle 4, RegWrite=0 throughout, ALUSrc=1.
REQ-038 Directed test, BEQ taken: instr=32'h00208463 with Zero=1 in EX -> PCSrc=1 and loadPC=1 in WB; repeat with Zero=1 only in MEM -> PCSrc=0.
REQ-039 Directed test, SRAI: instr=32'h4030D093 -> ALUCtrl=1010 and RegWrite=1 in WB; instr changed during EX -> no effect on outputs.
REQ-040 Directed test, reset in MEM of an SW: rst=0 -> next cycle MemWrite=0 and state=IF; after release, the next instruction completes normally.
REQ-041 Directed test, opcode 7'h7F: no write strobes, loadPC=1 and PCSrc=0 in WB.
